// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: Moore control outputs per state, a bounded memory-wait
// counter with timeout, and sticky illegal/timeout flags that park the FSM in ERROR.
module mips_mc_controller #(
    parameter int unsigned ENABLE_ADDI = 1,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExec    = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11,
        StError   = 4'd15
    } state_e;

    localparam logic [5:0] OpR    = 6'h00;
    localparam logic [5:0] OpLw   = 6'h23;
    localparam logic [5:0] OpSw   = 6'h2B;
    localparam logic [5:0] OpBeq  = 6'h04;
    localparam logic [5:0] OpAddi = 6'h08;
    localparam logic [5:0] OpJ    = 6'h02;

    localparam logic [2:0] AluAdd   = 3'd0;
    localparam logic [2:0] AluSub   = 3'd1;
    localparam logic [2:0] AluFunct = 3'd2;
    localparam logic [2:0] AluErr   = 3'd7;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;
    logic       waiting;

    assign waiting = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            StFetch:   if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLw, OpSw: state_d = StMemAddr;
                    OpR:        state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi: begin
                        if (ENABLE_ADDI != 0) begin
                            state_d = StAddiEx;
                        end else begin
                            state_d   = StError;
                            illegal_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = StError;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAddr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd:   if (mem_ready) state_d = StMemWb;
            StMemWb:   state_d = StFetch;
            StMemWr:   if (mem_ready) state_d = StFetch;
            StExec:    state_d = StRWb;
            StRWb:     state_d = StFetch;
            StBranch:  state_d = StFetch;
            StAddiEx:  state_d = StAddiWb;
            StAddiWb:  state_d = StFetch;
            StJump:    state_d = StFetch;
            StError:   state_d = StError;
            default:   state_d = StError;
        endcase
        // A ready in the final allowed wait cycle still completes normally.
        if (waiting && !mem_ready && (wait_q == TimeoutCnt)) begin
            state_d   = StError;
            timeout_d = 1'b1;
        end
        wait_d = (waiting && (state_d == state_q)) ? wait_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        pc_source     = 2'd0;
        alu_op        = AluAdd;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode:  alu_src_b = 2'd3;
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = AluFunct;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = AluSub;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            StAddiWb:  reg_write = 1'b1;
            StJump: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
            end
            StError:   alu_op = AluErr;
            default:   alu_op = AluErr;
        endcase
    end

    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench: three controller instances (default, ADDI disabled, TIMEOUT=4) share stimulus;
// each step queues the expected state/controls and checks the selected instance mid-cycle.
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;

    logic [16:0] ctl_o [3];
    logic [3:0]  st_o  [3];
    logic        ill_o [3];
    logic        to_o  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, ill, to;
        logic [1:0] asb, ps;
        logic [2:0] aop;
        logic [3:0] st;
        mips_mc_controller #(
            .ENABLE_ADDI((g == 1) ? 0 : 1),
            .TIMEOUT    ((g == 2) ? 4 : 15)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .opcode       (opcode),
            .mem_ready    (mem_ready),
            .pc_write     (pw),
            .pc_write_cond(pwc),
            .iord         (io),
            .mem_read     (mr),
            .mem_write    (mw),
            .ir_write     (irw),
            .mem_to_reg   (m2r),
            .reg_dst      (rd),
            .reg_write    (rw),
            .alu_src_a    (asa),
            .alu_src_b    (asb),
            .pc_source    (ps),
            .alu_op       (aop),
            .illegal      (ill),
            .timeout      (to),
            .state        (st)
        );
        assign ctl_o[g] = {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, ps, aop};
        assign st_o[g]  = st;
        assign ill_o[g] = ill;
        assign to_o[g]  = to;
    end

    typedef struct {
        int          d;
        logic [3:0]  st;
        logic [16:0] ctl;
        logic        ill;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected control vector straight from the per-state output table.
    function automatic logic [16:0] exp_ctl(input logic [3:0] st, input logic rdy);
        logic       pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, ps;
        logic [2:0] aop;
        {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa} = '0;
        asb = 2'd0; ps = 2'd0; aop = 3'd0;
        case (st)
            4'd0:  begin mr = 1; asb = 2'd1; pw = rdy; irw = rdy; end
            4'd1:  asb = 2'd3;
            4'd2:  begin asa = 1; asb = 2'd2; end
            4'd3:  begin mr = 1; io = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; io = 1; end
            4'd6:  begin asa = 1; aop = 3'd2; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 3'd1; pwc = 1; ps = 2'd1; end
            4'd9:  begin asa = 1; asb = 2'd2; end
            4'd10: rw = 1;
            4'd11: begin pw = 1; ps = 2'd2; end
            default: aop = 3'd7;
        endcase
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, ps, aop};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step(input string tag, input int d, input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input logic ill, input logic to);
        exp_t e;
        opcode    = op;
        mem_ready = rdy;
        e.d = d; e.st = st; e.ctl = exp_ctl(st, rdy); e.ill = ill; e.to = to;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        check_eq({tag, ".state"}, 32'(st_o[e.d]), 32'(e.st));
        check_eq({tag, ".ctl"}, 32'(ctl_o[e.d]), 32'(e.ctl));
        check_eq({tag, ".illegal"}, 32'(ill_o[e.d]), 32'(e.ill));
        check_eq({tag, ".timeout"}, 32'(to_o[e.d]), 32'(e.to));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // LW, zero wait: 0,1,2,3,4,0
        do_reset();
        step("lw0", 0, 6'h23, 1, 4'd0, 0, 0);
        step("lw1", 0, 6'h23, 1, 4'd1, 0, 0);
        step("lw2", 0, 6'h23, 1, 4'd2, 0, 0);
        step("lw3", 0, 6'h23, 1, 4'd3, 0, 0);
        step("lw4", 0, 6'h23, 1, 4'd4, 0, 0);
        step("lw5", 0, 6'h23, 1, 4'd0, 0, 0);

        // R-type with three FETCH wait cycles
        do_reset();
        for (int i = 0; i < 3; i++) step("rw_wait", 0, 6'h00, 0, 4'd0, 0, 0);
        step("r_fetch", 0, 6'h00, 1, 4'd0, 0, 0);
        step("r_dec", 0, 6'h00, 1, 4'd1, 0, 0);
        step("r_exec", 0, 6'h00, 1, 4'd6, 0, 0);
        step("r_wb", 0, 6'h00, 1, 4'd7, 0, 0);
        step("r_next", 0, 6'h00, 1, 4'd0, 0, 0);

        // Illegal opcode, sticky ERROR, cleared only by reset
        do_reset();
        step("ill_f", 0, 6'h3F, 1, 4'd0, 0, 0);
        step("ill_d", 0, 6'h3F, 1, 4'd1, 0, 0);
        for (int i = 0; i < 10; i++) step("ill_hold", 0, 6'h23, (i % 2) == 0, 4'd15, 1, 0);
        do_reset();
        step("ill_rst", 0, 6'h3F, 0, 4'd0, 0, 0);

        // ADDI disabled
        do_reset();
        step("na_f", 1, 6'h08, 1, 4'd0, 0, 0);
        step("na_d", 1, 6'h08, 1, 4'd1, 0, 0);
        step("na_err", 1, 6'h08, 1, 4'd15, 1, 0);

        // ADDI enabled
        do_reset();
        step("ad_f", 0, 6'h08, 1, 4'd0, 0, 0);
        step("ad_d", 0, 6'h08, 1, 4'd1, 0, 0);
        step("ad_ex", 0, 6'h08, 1, 4'd9, 0, 0);
        step("ad_wb", 0, 6'h08, 1, 4'd10, 0, 0);
        step("ad_next", 0, 6'h08, 1, 4'd0, 0, 0);

        // SW timeout with TIMEOUT=4: five cycles in MEM_WR then ERROR
        do_reset();
        step("to_f", 2, 6'h2B, 1, 4'd0, 0, 0);
        step("to_d", 2, 6'h2B, 1, 4'd1, 0, 0);
        step("to_a", 2, 6'h2B, 1, 4'd2, 0, 0);
        for (int i = 0; i < 5; i++) step("to_wr", 2, 6'h2B, 0, 4'd5, 0, 0);
        step("to_err", 2, 6'h2B, 0, 4'd15, 0, 1);
        step("to_hold", 2, 6'h2B, 1, 4'd15, 0, 1);

        // SW with ready on the last allowed cycle completes
        do_reset();
        step("ok_f", 2, 6'h2B, 1, 4'd0, 0, 0);
        step("ok_d", 2, 6'h2B, 1, 4'd1, 0, 0);
        step("ok_a", 2, 6'h2B, 1, 4'd2, 0, 0);
        for (int i = 0; i < 4; i++) step("ok_wr", 2, 6'h2B, 0, 4'd5, 0, 0);
        step("ok_wr5", 2, 6'h2B, 1, 4'd5, 0, 0);
        step("ok_next", 2, 6'h2B, 0, 4'd0, 0, 0);

        // BEQ then J
        do_reset();
        step("beq_f", 0, 6'h04, 1, 4'd0, 0, 0);
        step("beq_d", 0, 6'h04, 1, 4'd1, 0, 0);
        step("beq_b", 0, 6'h04, 1, 4'd8, 0, 0);
        step("j_f", 0, 6'h02, 1, 4'd0, 0, 0);
        step("j_d", 0, 6'h02, 1, 4'd1, 0, 0);
        step("j_j", 0, 6'h02, 1, 4'd11, 0, 0);
        step("j_next", 0, 6'h02, 0, 4'd0, 0, 0);

        // Reset during a MEM_RD wait
        do_reset();
        step("mr_f", 0, 6'h23, 1, 4'd0, 0, 0);
        step("mr_d", 0, 6'h23, 1, 4'd1, 0, 0);
        step("mr_a", 0, 6'h23, 1, 4'd2, 0, 0);
        step("mr_w0", 0, 6'h23, 0, 4'd3, 0, 0);
        step("mr_w1", 0, 6'h23, 0, 4'd3, 0, 0);
        do_reset();
        step("mr_rst", 0, 6'h23, 0, 4'd0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
